// File: rtl/numero_pkg.sv
// Shared types and the fixed BCD -> 2-of-5 (weights 7-4-2-1-0) code table.
package numero_pkg;

  typedef logic [4:0] code_t;  // {v, w, x, y, z}

  localparam code_t CODE_0       = 5'b11000;
  localparam code_t CODE_1       = 5'b00011;
  localparam code_t CODE_2       = 5'b00101;
  localparam code_t CODE_3       = 5'b00110;
  localparam code_t CODE_4       = 5'b01001;
  localparam code_t CODE_5       = 5'b01010;
  localparam code_t CODE_6       = 5'b01100;
  localparam code_t CODE_7       = 5'b10001;
  localparam code_t CODE_8       = 5'b10010;
  localparam code_t CODE_9       = 5'b10100;
  // All-zero is not a legal 2-of-5 word, so downstream can flag bad BCD.
  localparam code_t CODE_INVALID = 5'b00000;

endpackage

// File: rtl/numero_enc.sv
// Combinational BCD digit to 2-of-5 code lookup; non-BCD values map to CODE_INVALID.
module numero_enc
  import numero_pkg::*;
(
  input  logic [3:0] bcd,
  output code_t      code
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    code = CODE_INVALID;
    unique case (bcd)
      4'd0:    code = CODE_0;
      4'd1:    code = CODE_1;
      4'd2:    code = CODE_2;
      4'd3:    code = CODE_3;
      4'd4:    code = CODE_4;
      4'd5:    code = CODE_5;
      4'd6:    code = CODE_6;
      4'd7:    code = CODE_7;
      4'd8:    code = CODE_8;
      4'd9:    code = CODE_9;
      default: code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/numero.sv
// Registered BCD to 2-of-5 converter: loads on ready, holds otherwise, outputs straight from the register.
module numero
  import numero_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ready,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic out_v,
  output logic out_w,
  output logic out_x,
  output logic out_y,
  output logic out_z
);

  code_t enc_code;
  code_t code_q;

  numero_enc u_enc (
    .bcd  ({a, b, c, d}),
    .code (enc_code)
  );

  // Reset outranks ready; with neither, the register simply holds.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for registered state avoid simulation races.
    if (reset)
      code_q <= CODE_INVALID;
    else if (ready)
      code_q <= enc_code;
  end

  assign {out_v, out_w, out_x, out_y, out_z} = code_q;

endmodule

// File: tb/tb_numero.sv
// Scoreboard bench for numero: expected codes queued per edge, compared one cycle later.
module tb_numero;

  logic clk = 1'b0;
  logic reset, ready, a, b, c, d;
  logic out_v, out_w, out_x, out_y, out_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  logic [4:0] model_q;

  numero dut (
    .clk   (clk),
    .reset (reset),
    .ready (ready),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .out_v (out_v),
    .out_w (out_w),
    .out_x (out_x),
    .out_y (out_y),
    .out_z (out_z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end
  endtask

  // Reference encoder derived from the code weights: the two set bits sum to the digit (0 uses 7+4).
  function automatic logic [4:0] model_enc(input logic [3:0] n);
    int         w[5];
    int         target;
    logic [4:0] r;
    w = '{7, 4, 2, 1, 0};
    r = '0;
    if (n > 4'd9) return r;
    target = (n == 4'd0) ? 11 : int'(n);
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if (w[i] + w[j] == target) begin
          r[4-i] = 1'b1;
          r[4-j] = 1'b1;
        end
    return r;
  endfunction

  // Drive one edge worth of stimulus, queue the expected register value, then compare after the edge.
  task automatic step(input logic rst, input logic rdy, input logic [3:0] v,
                      input string tag, input bit pop_check);
    exp_t       e;
    logic [4:0] got;
    reset = rst;
    ready = rdy;
    {a, b, c, d} = v;
    if (rst)      model_q = 5'b00000;
    else if (rdy) model_q = model_enc(v);
    e.tag = tag;
    e.exp = model_q;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = {out_v, out_w, out_x, out_y, out_z};
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, {27'd0, got}, {27'd0, e.exp});
    end
    if (pop_check)
      check({tag, "_popcount"}, $countones(got), 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_q = 5'b00000;

    // Reset with ready high and valid data present, then idle.
    step(1'b1, 1'b1, 4'b0111, "reset", 1'b0);
    check("reset_const", {27'd0, out_v, out_w, out_x, out_y, out_z}, 32'd0);
    step(1'b0, 1'b0, 4'b0111, "idle_after_reset", 1'b0);

    // Sweep all legal digits with ready held high.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 4'(i), $sformatf("sweep_%0d", i), 1'b1);

    // Load 5, then change data with ready low for three cycles.
    step(1'b0, 1'b1, 4'b0101, "load_5", 1'b1);
    check("load_5_const", {27'd0, out_v, out_w, out_x, out_y, out_z}, 32'b01010);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'b1001, $sformatf("hold_%0d", i), 1'b1);

    // Invalid BCD loads the all-zero word; a legal digit recovers.
    step(1'b0, 1'b1, 4'b1010, "invalid_10", 1'b0);
    step(1'b0, 1'b1, 4'b1111, "invalid_15", 1'b0);
    step(1'b0, 1'b1, 4'b0011, "recover_3", 1'b1);
    check("recover_3_const", {27'd0, out_v, out_w, out_x, out_y, out_z}, 32'b00110);

    // Reset beats ready on the same edge, then the load goes through.
    step(1'b1, 1'b1, 4'b1000, "prio_reset", 1'b0);
    step(1'b0, 1'b1, 4'b1000, "prio_load_8", 1'b1);
    check("prio_load_8_const", {27'd0, out_v, out_w, out_x, out_y, out_z}, 32'b10010);

    // Mid-operation reset with ready low, then hold from the cleared state.
    step(1'b0, 1'b1, 4'b0110, "load_6", 1'b1);
    step(1'b1, 1'b0, 4'b0110, "midop_reset", 1'b0);
    step(1'b0, 1'b0, 4'b0001, "hold_zero", 1'b0);

    // A few random transactions through the scoreboard.
    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $sformatf("rand_%0d", i), 1'b0);

    if (sb_q.size() != 0)
      check("sb_leftover", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/numero.md
Name: numero

Overview:
- Registered BCD-to-2-out-of-5 code converter.
- A 4-bit BCD digit arrives on a (MSB), b, c, d. It is captured when ready is high and shown as a 5-bit 2-of-5 code on out_v..out_z.
- Sits between a digit source (keypad/counter) and a display/transmission stage that expects 2-of-5 encoding.

Parameters:
- None. The encoding table is fixed and held as package constants.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ready  input  1  load strobe; level-sampled on the rising clk edge.
- a  input  1  BCD bit 3 (MSB, weight 8).
- b  input  1  BCD bit 2 (weight 4).
- c  input  1  BCD bit 1 (weight 2).
- d  input  1  BCD bit 0 (LSB, weight 1).
- out_v  output  1  code bit, weight 7.
- out_w  output  1  code bit, weight 4.
- out_x  output  1  code bit, weight 2.
- out_y  output  1  code bit, weight 1.
- out_z  output  1  code bit, weight 0 (parity-like fill).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Outputs come straight from a 5-bit register. No combinational path from inputs to outputs.
- Reset: at a rising clk with reset=1, {out_v,out_w,out_x,out_y,out_z} = 00000.
  - Reset has priority over ready.
  - Reset asserted mid-operation clears the register on that edge, regardless of ready or data.
- Load: at a rising clk with reset=0 and ready=1, the register takes encode({a,b,c,d}).
  - Latency: 1 cycle from the sampling edge to valid output.
- Hold: with reset=0 and ready=0, the register keeps its value indefinitely.
- ready needs no edge detection. Holding ready high reloads on every edge, so output tracks the input with 1-cycle lag.
- Encoding, 2-of-5 with weights 7-4-2-1-0, listed as input -> vwxyz:
  - 0 -> 11000
  - 1 -> 00011
  - 2 -> 00101
  - 3 -> 00110
  - 4 -> 01001
  - 5 -> 01010
  - 6 -> 01100
  - 7 -> 10001
  - 8 -> 10010
  - 9 -> 10100
- Invalid BCD inputs 10..15 load 00000 when ready=1.
  - 00000 is not a legal 2-of-5 word, so downstream can detect the error.
- Every valid code has exactly two ones.
- Before the first reset, output is undefined. The system must apply reset first.

Decomposition:
- Package numero_pkg:
  - 5-bit code type.
  - Constants CODE_0..CODE_9 and CODE_INVALID (00000).
- One combinational sub-module, numero_enc: 4-bit BCD in, 5-bit code out, implemented as a case on the package constants.
- Top numero holds the register, the reset/ready priority logic, and the port bit mapping.

Test Plan:
- Reset: reset=1 for one edge with ready=1 and abcd=0111 -> output 00000. Then reset=0, ready=0 -> stays 00000.
- Sweep: ready=1, abcd = 0000..1001 on successive edges -> output one cycle later follows the encoding list in order (11000, 00011, 00101, … 10100). Each word has popcount 2.
- Hold: load 0101 (output 01010), then ready=0 and change abcd to 1001 for 3 cycles -> output stays 01010.
- Invalid: ready=1, abcd=1010, then 1111 -> output 00000 each. Then abcd=0011 -> 00110.
- Priority: reset=1 and ready=1 with abcd=1000 on the same edge -> 00000. Next edge reset=0, ready=1 -> 10010.
